// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns a raw, bouncy, asynchronous push-button pad into a glitch-free
//   level on `clock`. The pad goes through a two-flop synchronizer. A
//   four-state FSM then accepts a change of level only after the
//   synchronized input has held the new value for STABLE_CYCLES
//   consecutive clocks. `clean` feeds the `w` input of the downstream
//   rising-edge detector that starts the signed SPM controller.
//
//   Optional build macro: DEBOUNCE_GLITCH_CNT_EN
//     When defined, the design adds an 8-bit `glitch_count` output. It
//     counts aborted qualifications (RISE_CHK->LOW and FALL_CHK->HIGH),
//     saturates at 255 and is cleared only by reset. When the macro is
//     undefined, the port and its logic are absent. Everything else
//     behaves identically.

module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH     = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       clean,
  output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  // FSM encoding. The LSB is set exactly in the two qualifying states.
  localparam logic [1:0] LOW      = 2'd0;
  localparam logic [1:0] RISE_CHK = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] FALL_CHK = 2'd3;

  // Terminal count. cnt never goes past it, so the counter never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 clean_nxt;
  logic                 busy_nxt;
  logic                 cnt_done;

  assign cnt_done = (cnt == CNT_LAST);

  // Two-flop synchronizer: only s2 is safe for the FSM to look at.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Next-state logic: qualify each candidate level change for STABLE_CYCLES clocks.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = '0;
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          // Input fell back before it was accepted: this was a bounce.
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt_done) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          clean_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = '0;
        end
      end
      FALL_CHK: begin
        if (s2) begin
          // Input rose back before the release was accepted: a bounce.
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt_done) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          clean_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        clean_nxt = 1'b0;
      end
    endcase
    // busy is registered alongside the state, so it marks the qualifying states exactly.
    busy_nxt = (state_nxt == RISE_CHK) || (state_nxt == FALL_CHK);
  end

  // State, counter and registered outputs. Reset wipes any partial qualification.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
      clean <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
      busy  <= busy_nxt;
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort;

  assign abort = ((state == RISE_CHK) && !s2) || ((state == FALL_CHK) && s2);

  // Saturating count of rejected bounces. Only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      glitch_count <= 8'd0;
    end else if (abort && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer. It instantiates two copies: dut4
// (STABLE_CYCLES=4) and dut1 (STABLE_CYCLES=1). Every clock, a
// run-length reference model predicts clean/busy/glitch_count for both
// copies. The predictions are queued when the stimulus is driven and
// compared after the edge. Explicit latency and duration checks are
// layered on top.

module tb_button_debouncer;

  logic clock = 1'b0;
  logic r4, b4, r1, b1;
  logic clean4, busy4, clean1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gc4, gc1;
`endif

  always #5 clock = ~clock;

  button_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(20)) dut4 (
    .clock(clock), .reset(r4), .btn_raw(b4), .clean(clean4), .busy(busy4)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc4)
`endif
  );

  button_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(20)) dut1 (
    .clock(clock), .reset(r1), .btn_raw(b1), .clean(clean1), .busy(busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. `run` counts consecutive edges at which the
  // synchronized input differed from the accepted level. The level
  // flips when the count reaches S+1: one edge to enter the check,
  // then S qualifying edges.
  int ms  [2] = '{4, 1};
  int ms1 [2] = '{0, 0};
  int ms2 [2] = '{0, 0};
  int mcl [2] = '{0, 0};
  int mrun[2] = '{0, 0};
  int mgl [2] = '{0, 0};

  typedef struct {
    int id;
    int cl;
    int bs;
    int gl;
  } exp_t;

  exp_t sbq[$];

  task automatic model(input int id, input logic r, input logic b);
    if (r) begin
      ms1[id] = 0; ms2[id] = 0; mcl[id] = 0; mrun[id] = 0; mgl[id] = 0;
    end else begin
      if (ms2[id] != mcl[id]) begin
        mrun[id]++;
        if (mrun[id] == ms[id] + 1) begin
          mcl[id]  = 1 - mcl[id];
          mrun[id] = 0;
        end
      end else begin
        if (mrun[id] > 0 && mgl[id] < 255) mgl[id]++;
        mrun[id] = 0;
      end
      ms2[id] = ms1[id];
      ms1[id] = int'(b);
    end
  endtask

  // One clock: predict, queue the expectations, take the edge, then drain and compare.
  task automatic step();
    exp_t e;
    model(0, r4, b4);
    model(1, r1, b1);
    for (int id = 0; id < 2; id++) begin
      e.id = id; e.cl = mcl[id]; e.bs = (mrun[id] > 0) ? 1 : 0; e.gl = mgl[id];
      sbq.push_back(e);
    end
    @(posedge clock);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.id == 0) begin
        chk("clean4", int'(clean4), e.cl);
        chk("busy4", int'(busy4), e.bs);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch4", int'(gc4), e.gl);
`endif
      end else begin
        chk("clean1", int'(clean1), e.cl);
        chk("busy1", int'(busy1), e.bs);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch1", int'(gc1), e.gl);
`endif
      end
    end
  endtask

  function automatic int get_clean(input int id);
    return (id == 0) ? int'(clean4) : int'(clean1);
  endfunction

  // Steps with the inputs as set until clean reaches val. Returns the
  // number of edges taken, or -1 if the budget runs out.
  task automatic wait_clean(input int id, input int val, input int maxn, output int n);
    n = -1;
    for (int i = 1; i <= maxn; i++) begin
      step();
      if (get_clean(id) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic reset4();
    r4 = 1'b1; b4 = 1'b0;
    step();
    r4 = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nbusy;
    int npulse;
    int seen_hi;
    r4 = 1'b1; b4 = 1'b1; r1 = 1'b1; b1 = 1'b0;

    // T1: reset held for two edges with the button pressed, then released.
    step();
    step();
    chk("t1_rst_clean", int'(clean4), 0);
    chk("t1_rst_busy", int'(busy4), 0);
    r4 = 1'b0;
    wait_clean(0, 1, 20, n);
    chk("t1_rise_latency", n, 7);

    // T2: clean press held for 20 cycles, then clean release.
    reset4();
    nbusy = 0; n = -1;
    b4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy4) nbusy++;
      if (clean4 && n < 0) n = i;
    end
    chk("t2_busy_cycles", nbusy, 4);
    chk("t2_rise_latency", n, 7);
    chk("t2_clean_held", int'(clean4), 1);
    b4 = 1'b0;
    wait_clean(0, 0, 20, n);
    chk("t2_fall_latency", n, 7);
    for (int i = 0; i < 3; i++) step();

    // T3: bounce 1,0,1,1,0,1, then steady high.
    reset4();
    seen_hi = 0;
    for (int i = 0; i < 6; i++) begin
      b4 = (i == 1 || i == 4) ? 1'b0 : 1'b1;
      step();
      if (clean4) seen_hi = 1;
    end
    chk("t3_no_rise_in_bounce", seen_hi, 0);
    b4 = 1'b1;
    wait_clean(0, 1, 20, n);
    chk("t3_rise_after_last_edge", n, 6);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("t3_glitches", int'(gc4), 2);
`endif

    // T4: single-cycle pulses every third clock are all absorbed.
    reset4();
    seen_hi = 0; npulse = 0;
    for (int i = 0; i < 102; i++) begin
      b4 = (i % 3 == 0) ? 1'b1 : 1'b0;
      if (b4) npulse++;
      step();
      if (clean4) seen_hi = 1;
    end
    b4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (clean4) seen_hi = 1;
    end
    chk("t4_never_rises", seen_hi, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("t4_glitches_eq_pulses", int'(gc4), npulse);
`endif

    // T5: reset in the middle of a rising qualification.
    reset4();
    b4 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t5_busy_before", int'(busy4), 1);
    chk("t5_cnt_before", int'(dut4.cnt), 2);
    r4 = 1'b1;
    step();
    chk("t5_cnt_after_rst", int'(dut4.cnt), 0);
    chk("t5_clean_after_rst", int'(clean4), 0);
    r4 = 1'b0;
    wait_clean(0, 1, 20, n);
    chk("t5_full_latency_again", n, 7);

    // T6: STABLE_CYCLES=1. 300 glitches, then a two-cycle press.
    r4 = 1'b0; b4 = 1'b0;
    r1 = 1'b1; b1 = 1'b0;
    step();
    r1 = 1'b0;
    step();
    seen_hi = 0;
    for (int i = 0; i < 600; i++) begin
      b1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      if (clean1) seen_hi = 1;
    end
    b1 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_glitch_no_rise", seen_hi, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("t6_glitch_saturated", int'(gc1), 255);
`endif
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      b1 = (i <= 2) ? 1'b1 : 1'b0;
      step();
      if (clean1 && n < 0) n = i;
    end
    chk("t6_short_rise_latency", n, 4);
    chk("t6_clean_back_low", int'(clean1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
